bcd_conv_sched: RTL and testbench
=================================

Name: bcd_conv_sched

Overview:
- Time-shares one iterative binary-to-BCD engine between two requesters: channel T (temperature) and channel L (level).
- Each converted result is held in its own output register, DT or DL, for the display / readout logic.
- Replaces the pair of parallel combinational converters with one shift-add-3 engine, saving area.
- Adds a req/ack handshake and round-robin arbitration between the two channels.

Parameters:
- W, 8: binary operand width of T and L.
- ND, 3: BCD digit count. ND*4 must hold 2^W-1; the pair (8,3) is the only supported combination.

Ports:
- clk  in  1  system clock; all logic updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- T  in  W  channel T binary operand.
- L  in  W  channel L binary operand.
- req_t  in  1  channel T request; level, held by the requester until ack_t.
- req_l  in  1  channel L request; level, held by the requester until ack_l.
- ack_t  out  1  one-cycle pulse; DT updated in the same cycle.
- ack_l  out  1  one-cycle pulse; DL updated in the same cycle.
- DT  out  ND*4  registered BCD result for channel T, digits [11:8]=hundreds, [7:4]=tens, [3:0]=ones.
- DL  out  ND*4  registered BCD result for channel L, same digit layout.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high, ports named clk and rst.
- Reset values:
  - DT = 0, DL = 0, ack_t = 0, ack_l = 0, busy = 0.
  - State = IDLE, last-grant pointer = L (so T wins the first tie).
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with req_t or req_l high, grant one channel.
  - Capture its operand into the engine and latch the channel ID.
  - Clear the BCD accumulator, set cnt = 0, go to SHIFT.
  - With no request, stay in IDLE.
- Arbitration:
  - Only one request high: grant it.
  - Both high: grant the channel that was not granted last.
  - The pointer updates at the grant edge.
- SHIFT, once per cycle:
  - Every BCD digit >= 5 gets +3.
  - Then {bcd, operand} shifts left by one bit; the operand MSB enters the BCD LSB.
  - cnt increments; the edge with cnt == W-1 moves to DONE (W shifts in total).
- DONE:
  - On the next edge, write the accumulator to DT or DL per the latched channel.
  - Assert the matching ack for exactly that one following cycle, then return to IDLE.
- Latency: grant edge e0, shifts on e1..e8, result and ack visible after e9.
- Throughput: IDLE may grant again at e10, giving one conversion per 10 cycles.
- Operand sampling: T and L are sampled only at the grant edge. Later changes do not affect the running conversion.
- Request dropped mid-conversion: no abort; the result is still written and ack still pulses.
- Request still high after ack: treated as a new request, which gives continuous-refresh mode. Alternation is guaranteed when both channels are held.
- Holding: DT and DL keep their value between updates; the non-granted channel's register never changes.
- Range: the maximum input 255 gives 0x255. No overflow is possible with (8,3).
- Reset mid-conversion: the conversion is aborted, all outputs and state take their reset values, and no ack is issued.

Decomposition:
- Shared package holds:
  - state encodings IDLE/SHIFT/DONE;
  - channel ID constants CH_T = 0, CH_L = 1;
  - W and ND defaults;
  - the ADD3_THRESH = 5 constant.
- Sub-module bcd_dd_engine (the shift-add-3 datapath):
  - Ports: clk, rst, load, bin[W-1:0], step, bcd[ND*4-1:0].
  - On load: clear the accumulator and capture bin.
  - On step: one add-3/shift iteration.
- The top level holds the FSM, the counter, the arbiter and the output registers.

Test Plan:
- Single request: T=123, pulse req_t until ack -> ack_t high exactly 1 cycle, 10 edges after the grant edge; DT=0x123; DL stays 0x000; ack_l never asserts.
- Simultaneous requests after reset: T=9, L=231, both requests asserted -> T served first, DT=0x009; then DL=0x231 with ack_l 10 cycles after ack_t.
- Continuous mode: both requests held high, L=100, T=0 -> acks alternate t,l,t,l at a 10-cycle spacing; DT=0x000, DL=0x100; busy low for only 1 cycle between conversions.
- Operand change mid-conversion: T=40, grant, then T=199 at shift 3 -> DT=0x040. A following request converts to 0x199.
- Boundary values: L=255 -> DL=0x255; L=0 -> DL=0x000; T=99 -> DT=0x099; T=200 -> DT=0x200.
- Reset mid-conversion: rst at shift 5 of a T conversion -> next cycle DT=0, busy=0, no ack_t. After release with req_t still high, a fresh conversion completes correctly.

Source files
------------

// File: rtl/bcd_conv_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_conv_sched_pkg
// Description : Shared types and constants for the time-shared binary-to-BCD
//               converter (state encoding, channel IDs, default widths).
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_conv_sched_pkg;

    // Default operand width and BCD digit count; (8,3) is the supported pair.
    localparam int DEF_W  = 8;
    localparam int DEF_ND = 3;

    // A BCD digit at or above this value is corrected by +3 before shifting.
    localparam logic [3:0] ADD3_THRESH = 4'd5;

    // Channel identifiers, also used as the round-robin pointer value.
    localparam logic CH_T = 1'b0;
    localparam logic CH_L = 1'b1;

    // Conversion scheduler states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bcd_dd_engine.sv
`default_nettype none
// ============================================================================
// Module      : bcd_dd_engine
// Description : Iterative double-dabble (shift-add-3) datapath. Load clears
//               the BCD accumulator and captures the operand; each step does
//               one add-3 correction followed by a one-bit left shift.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_dd_engine
    import bcd_conv_sched_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int ND = DEF_ND
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [W-1:0]      bin,
    input  logic              step,
    output logic [ND*4-1:0]   bcd
);

    logic [ND*4-1:0] acc_q, acc_d;
    logic [W-1:0]    opnd_q, opnd_d;
    logic [ND*4-1:0] w_adj;

    // Per-digit add-3 correction applied to the accumulator before the shift.
    generate
        for (genvar i = 0; i < ND; i++) begin : g_digit
            assign w_adj[i*4 +: 4] = (acc_q[i*4 +: 4] >= ADD3_THRESH)
                                   ? acc_q[i*4 +: 4] + 4'd3
                                   : acc_q[i*4 +: 4];
        end
    endgenerate

    // Next-state: load takes priority; a step shifts the operand MSB into the BCD LSB.
    always_comb begin
        acc_d  = acc_q;
        opnd_d = opnd_q;
        if (load) begin
            acc_d  = '0;
            opnd_d = bin;
        end else if (step) begin
            {acc_d, opnd_d} = {w_adj[ND*4-2:0], opnd_q, 1'b0};
        end
    end

    // Accumulator and operand shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            opnd_q <= '0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
        end
    end

    assign bcd = acc_q;

endmodule
`default_nettype wire

// File: rtl/bcd_conv_sched.sv
`default_nettype none
// ============================================================================
// Module      : bcd_conv_sched
// Description : Shares one shift-add-3 engine between channels T and L with
//               req/ack handshaking and round-robin arbitration. Results are
//               held in DT / DL until the owning channel is converted again.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_conv_sched
    import bcd_conv_sched_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int ND = DEF_ND
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W-1:0]      T,
    input  logic [W-1:0]      L,
    input  logic              req_t,
    input  logic              req_l,
    output logic              ack_t,
    output logic              ack_l,
    output logic [ND*4-1:0]   DT,
    output logic [ND*4-1:0]   DL,
    output logic              busy
);

    localparam int                 c_cnt_w    = $clog2(W);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(W - 1);

    state_t             state_q, state_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic               last_q, last_d;   // channel granted most recently
    logic               ch_q, ch_d;       // channel owning the running conversion
    logic [ND*4-1:0]    dt_q, dt_d;
    logic [ND*4-1:0]    dl_q, dl_d;
    logic               ack_t_q, ack_t_d;
    logic               ack_l_q, ack_l_d;

    logic               w_req_any;
    logic               w_grant_ch;
    logic               w_load;
    logic               w_step;
    logic [W-1:0]       w_bin;
    logic [ND*4-1:0]    w_bcd;

    // Round-robin choice: on a tie the channel not granted last time wins.
    always_comb begin
        w_req_any = req_t | req_l;
        if (req_t && req_l) begin
            w_grant_ch = (last_q == CH_T) ? CH_L : CH_T;
        end else if (req_t) begin
            w_grant_ch = CH_T;
        end else begin
            w_grant_ch = CH_L;
        end
    end

    assign w_load = (state_q == IDLE) && w_req_any;
    assign w_step = (state_q == SHIFT);
    assign w_bin  = (w_grant_ch == CH_T) ? T : L;

    bcd_dd_engine #(
        .W  (W),
        .ND (ND)
    ) u_engine (
        .clk  (clk),
        .rst  (rst),
        .load (w_load),
        .bin  (w_bin),
        .step (w_step),
        .bcd  (w_bcd)
    );

    // Scheduler next-state: grant, W shift cycles, then write-back with ack.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        ch_d    = ch_q;
        dt_d    = dt_q;
        dl_d    = dl_q;
        ack_t_d = 1'b0;
        ack_l_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_req_any) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    ch_d    = w_grant_ch;
                    last_d  = w_grant_ch;
                end
            end
            SHIFT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == c_cnt_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (ch_q == CH_T) begin
                    dt_d    = w_bcd;
                    ack_t_d = 1'b1;
                end else begin
                    dl_d    = w_bcd;
                    ack_l_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Single register bank for the FSM, counter, arbiter pointer and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= CH_L;
            ch_q    <= CH_T;
            dt_q    <= '0;
            dl_q    <= '0;
            ack_t_q <= 1'b0;
            ack_l_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            ch_q    <= ch_d;
            dt_q    <= dt_d;
            dl_q    <= dl_d;
            ack_t_q <= ack_t_d;
            ack_l_q <= ack_l_d;
        end
    end

    assign ack_t = ack_t_q;
    assign ack_l = ack_l_q;
    assign DT    = dt_q;
    assign DL    = dl_q;
    assign busy  = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bcd_conv_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_conv_sched
// Description : Directed self-checking bench for bcd_conv_sched. Expected
//               results go into a scoreboard queue when requests are driven
//               and are popped by a monitor whenever an ack appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_conv_sched;

    typedef struct packed {
        logic        ch;    // 0 = T, 1 = L
        logic [11:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  T, L;
    logic        req_t, req_l;
    logic        ack_t, ack_l, busy;
    logic [11:0] DT, DL;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [11:0] dt_m = '0;
    logic [11:0] dl_m = '0;

    bcd_conv_sched dut (
        .clk   (clk),
        .rst   (rst),
        .T     (T),
        .L     (L),
        .req_t (req_t),
        .req_l (req_l),
        .ack_t (ack_t),
        .ack_l (ack_l),
        .DT    (DT),
        .DL    (DL),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Reference conversion: decimal digits packed as nibbles.
    function automatic logic [11:0] to_bcd(input int v);
        return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic ch, input int v);
        exp_t e;
        e.ch  = ch;
        e.val = to_bcd(v);
        sb.push_back(e);
    endtask

    // Monitor: reset model on reset edges, pop expectations on acks, check holding.
    logic prev_t = 1'b0;
    logic prev_l = 1'b0;
    always @(posedge clk) begin : mon
        logic r;
        exp_t e;
        r = rst;
        #1;
        if (r) begin
            dt_m = '0;
            dl_m = '0;
            sb.delete();
            check("rst_ack_t", 32'(ack_t), 0);
            check("rst_ack_l", 32'(ack_l), 0);
            check("rst_busy",  32'(busy),  0);
            check("rst_DT",    32'(DT),    0);
            check("rst_DL",    32'(DL),    0);
            prev_t = 1'b0;
            prev_l = 1'b0;
        end else begin
            check("ack_exclusive", 32'(ack_t & ack_l), 0);
            check("ack_t_pulse",   32'(prev_t & ack_t), 0);
            check("ack_l_pulse",   32'(prev_l & ack_l), 0);
            if (ack_t) begin
                check("ack_t_expected", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("ack_t_order", 32'(e.ch), 0);
                    dt_m = e.val;
                end
            end
            if (ack_l) begin
                check("ack_l_expected", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("ack_l_order", 32'(e.ch), 1);
                    dl_m = e.val;
                end
            end
            check("DT_value", 32'(DT), 32'(dt_m));
            check("DL_value", 32'(DL), 32'(dl_m));
            prev_t = ack_t;
            prev_l = ack_l;
        end
    end

    // Wait for n acks; every ack must land 10 edges after the grant / previous ack.
    // 'start' is the number of edges since the grant already consumed by the caller.
    task automatic collect(input int n, input bit hold, input int start, input string tag);
        int edges;
        int got;
        int last_edge;
        int busy_low;
        edges     = start;
        got       = 0;
        last_edge = 0;
        busy_low  = 0;
        while (got < n && edges < start + 15 * n + 20) begin
            @(posedge clk);
            #1;
            edges++;
            if (!busy) busy_low++;
            if (ack_t || ack_l) begin
                check({tag, "_ack_spacing"}, 32'(edges - last_edge), 10);
                last_edge = edges;
                got++;
                if (!hold) begin
                    if (ack_t) req_t = 1'b0;
                    if (ack_l) req_l = 1'b0;
                end
                if (got == n) begin
                    req_t = 1'b0;
                    req_l = 1'b0;
                end
            end
        end
        check({tag, "_ack_count"}, 32'(got), 32'(n));
        check({tag, "_busy_low"}, 32'(busy_low), 32'(n));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic       bnd_ch  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    int         bnd_in  [4] = '{255, 0, 99, 200};
    logic [11:0] bnd_exp[4] = '{12'h255, 12'h000, 12'h099, 12'h200};

    initial begin
        rst   = 1'b1;
        req_t = 1'b0;
        req_l = 1'b0;
        T     = '0;
        L     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_DT",   32'(DT),   0);
        check("reset_DL",   32'(DL),   0);
        check("reset_busy", 32'(busy), 0);
        rst = 1'b0;

        // Single T request
        @(negedge clk);
        T = 8'd123; req_t = 1'b1;
        push_exp(1'b0, 123);
        collect(1, 1'b0, 0, "single");
        check("single_DT", 32'(DT), 32'h123);
        check("single_DL", 32'(DL), 32'h000);

        // Simultaneous requests right after reset: T wins the first tie
        do_reset();
        @(negedge clk);
        T = 8'd9; L = 8'd231; req_t = 1'b1; req_l = 1'b1;
        push_exp(1'b0, 9);
        push_exp(1'b1, 231);
        collect(2, 1'b0, 0, "simul");
        check("simul_DT", 32'(DT), 32'h009);
        check("simul_DL", 32'(DL), 32'h231);

        // Continuous refresh with both requests held: strict alternation
        @(negedge clk);
        T = 8'd0; L = 8'd100; req_t = 1'b1; req_l = 1'b1;
        push_exp(1'b0, 0);
        push_exp(1'b1, 100);
        push_exp(1'b0, 0);
        push_exp(1'b1, 100);
        collect(4, 1'b1, 0, "cont");
        check("cont_DT", 32'(DT), 32'h000);
        check("cont_DL", 32'(DL), 32'h100);

        // Operand change after shift 3 must not disturb the running conversion
        @(negedge clk);
        T = 8'd40; req_t = 1'b1;
        push_exp(1'b0, 40);
        repeat (4) @(posedge clk);
        #1;
        T = 8'd199;
        collect(1, 1'b0, 4, "opchg");
        check("opchg_DT", 32'(DT), 32'h040);
        @(negedge clk);
        req_t = 1'b1;
        push_exp(1'b0, 199);
        collect(1, 1'b0, 0, "opchg2");
        check("opchg2_DT", 32'(DT), 32'h199);

        // Boundary operands
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bnd_ch[i]) begin
                L = 8'(bnd_in[i]); req_l = 1'b1;
            end else begin
                T = 8'(bnd_in[i]); req_t = 1'b1;
            end
            push_exp(bnd_ch[i], bnd_in[i]);
            collect(1, 1'b0, 0, "boundary");
            check("boundary_result", 32'(bnd_ch[i] ? DL : DT), 32'(bnd_exp[i]));
        end

        // Reset during shift 5 aborts; a held request then converts afresh
        @(negedge clk);
        T = 8'd77; req_t = 1'b1;
        push_exp(1'b0, 77);
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_DT",    32'(DT),    0);
        check("abort_busy",  32'(busy),  0);
        check("abort_ack_t", 32'(ack_t), 0);
        @(negedge clk);
        rst = 1'b0;
        push_exp(1'b0, 77);
        collect(1, 1'b0, 0, "recover");
        check("recover_DT", 32'(DT), 32'h077);

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
